// File: rtl/pwm_pkg.sv
// ----------------------------------------------------------------------------
// pwm_pkg
// Shared constants and types for the 8-bit PWM generator and its sample feeder.
//   PWM_WIDTH          : duty value width
//   PWM_PERIOD         : clocks per PWM period
//   IDLE_LEVEL_DEFAULT : midscale duty (silence)
//   feeder_state_t     : sample feeder FSM states
// ----------------------------------------------------------------------------
package pwm_pkg;

   localparam int PWM_WIDTH  = 8;
   localparam int PWM_PERIOD = 256;

   localparam logic [PWM_WIDTH-1:0] IDLE_LEVEL_DEFAULT = 8'h80;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } feeder_state_t;

endpackage

// File: rtl/sample_fifo.sv
// ----------------------------------------------------------------------------
// sample_fifo
// Synchronous single-clock show-ahead FIFO. The head entry is always visible on
// rd_data_o; pop_i advances past it. Pointers wrap modulo DEPTH (power of two).
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (control only)
//   push_i, wr_data_i : write request and data (ignored when full)
//   pop_i           : read advance (ignored when empty)
//   rd_data_o       : head entry
//   level_o         : registered occupancy 0..DEPTH
//   full_o, empty_o : status flags derived from level
// ----------------------------------------------------------------------------
module sample_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      level_q;
   logic [AW:0]      level_d;
   logic             push_ok;
   logic             pop_ok;

   assign full_o    = (level_q == FULL_LVL);
   assign empty_o   = (level_q == '0);
   assign push_ok   = push_i && !full_o;
   assign pop_ok    = pop_i && !empty_o;
   assign rd_data_o = mem_q[rd_ptr_q];
   assign level_o   = level_q;

   always_comb begin
      level_d = level_q;
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q <= level_d;
      end
   end

   // Storage carries no reset; only pointers and level define validity.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/pwm_sample_feeder.sv
// ----------------------------------------------------------------------------
// pwm_sample_feeder
// Buffers 8-bit unsigned samples and presents one per sample period as the PWM
// duty. Duty only changes at a PWM period boundary (phase 0), so each 256-clock
// PWM period sees a single stable value.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   enable         : 1 = play, 0 = stop (FIFO contents kept)
//   s_data/s_valid/s_ready : sample input handshake; s_ready = !full
//   pwm_duty       : registered duty to the PWM stage
//   sample_tick    : pulse in the first cycle a new duty is visible
//   underrun       : pulse in the cycle after a slot that found the FIFO empty
//   underrun_count : saturating underrun counter (only with
//                    PWM_FEEDER_UNDERRUN_CNT_EN defined)
//   fifo_level     : samples held, 0..DEPTH
// ----------------------------------------------------------------------------
module pwm_sample_feeder
   import pwm_pkg::*;
#(
   parameter int                    DEPTH              = 16,
   parameter int                    PERIODS_PER_SAMPLE = 4,
   parameter logic [PWM_WIDTH-1:0]  IDLE_LEVEL         = IDLE_LEVEL_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic [PWM_WIDTH-1:0]     s_data,
   input  logic                     s_valid,
   output logic                     s_ready,
   output logic [PWM_WIDTH-1:0]     pwm_duty,
   output logic                     sample_tick,
   output logic                     underrun,
`ifdef PWM_FEEDER_UNDERRUN_CNT_EN
   output logic [15:0]              underrun_count,
`endif
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int LW   = $clog2(DEPTH) + 1;
   localparam int PERW = (PERIODS_PER_SAMPLE > 1) ? $clog2(PERIODS_PER_SAMPLE) : 1;
   localparam logic [PERW-1:0]      LAST_PERIOD = PERW'(PERIODS_PER_SAMPLE - 1);
   localparam logic [PWM_WIDTH-1:0] PHASE_MAX   = PWM_WIDTH'(PWM_PERIOD - 1);
   localparam logic [LW-1:0]        PRIME_LVL   = LW'(DEPTH / 2);

   feeder_state_t          state_q;
   logic [PWM_WIDTH-1:0]   phase_q;
   logic [PERW-1:0]        period_q;
   logic [PWM_WIDTH-1:0]   duty_q;
   logic                   tick_q;
   logic                   underrun_q;

   logic                   push;
   logic                   pop;
   logic                   slot;
   logic                   full;
   logic                   empty;
   logic [PWM_WIDTH-1:0]   head;
   logic [LW-1:0]          level;

   assign s_ready = !full;
   assign push    = s_valid && s_ready;
   // Dropping enable takes priority over a coincident slot, so nothing is popped.
   assign slot    = (state_q == RUN) && enable && (phase_q == PHASE_MAX) &&
                    (period_q == LAST_PERIOD);
   assign pop     = slot && !empty;

   sample_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (PWM_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_i    (push),
      .wr_data_i (s_data),
      .pop_i     (pop),
      .rd_data_o (head),
      .level_o   (level),
      .full_o    (full),
      .empty_o   (empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         phase_q    <= '0;
         period_q   <= '0;
         duty_q     <= IDLE_LEVEL;
         tick_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         tick_q     <= 1'b0;
         underrun_q <= 1'b0;
         case (state_q)
            IDLE: begin
               duty_q   <= IDLE_LEVEL;
               phase_q  <= '0;
               period_q <= '0;
               if (enable) state_q <= PRIME;
            end
            PRIME: begin
               duty_q   <= IDLE_LEVEL;
               phase_q  <= '0;
               period_q <= '0;
               if (!enable)                 state_q <= IDLE;
               else if (level >= PRIME_LVL) state_q <= RUN;
            end
            RUN: begin
               if (!enable) begin
                  state_q  <= IDLE;
                  duty_q   <= IDLE_LEVEL;
                  phase_q  <= '0;
                  period_q <= '0;
               end else begin
                  phase_q <= phase_q + PWM_WIDTH'(1);
                  if (phase_q == PHASE_MAX)
                     period_q <= (period_q == LAST_PERIOD) ? '0 : period_q + PERW'(1);
                  // A sample pushed in this same cycle is not yet visible, so an
                  // empty FIFO here is an underrun even if s_valid is high.
                  if (slot) begin
                     if (!empty) begin
                        duty_q <= head;
                        tick_q <= 1'b1;
                     end else begin
                        underrun_q <= 1'b1;
                     end
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef PWM_FEEDER_UNDERRUN_CNT_EN
   logic [15:0] ucnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                ucnt_q <= '0;
      else if (underrun_q && ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 16'd1;
   end

   assign underrun_count = ucnt_q;
`endif

   assign pwm_duty    = duty_q;
   assign sample_tick = tick_q;
   assign underrun    = underrun_q;
   assign fifo_level  = level;

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// ----------------------------------------------------------------------------
// tb_pwm_sample_feeder
// Directed bench for pwm_sample_feeder with DEPTH=16, PERIODS_PER_SAMPLE=1,
// so a slot occurs every 256 clocks once RUN is entered. Inputs change and
// outputs are sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_pwm_sample_feeder;

   localparam int DEPTH = 16;
   localparam int PPS   = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  pwm_duty;
   logic        sample_tick;
   logic        underrun;
   logic [4:0]  fifo_level;
`ifdef PWM_FEEDER_UNDERRUN_CNT_EN
   logic [15:0] underrun_count;
`endif

   int n_checks = 0;
   int n_errors = 0;

   pwm_sample_feeder #(
      .DEPTH              (DEPTH),
      .PERIODS_PER_SAMPLE (PPS),
      .IDLE_LEVEL         (8'h80)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .s_data         (s_data),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .pwm_duty       (pwm_duty),
      .sample_tick    (sample_tick),
      .underrun       (underrun),
`ifdef PWM_FEEDER_UNDERRUN_CNT_EN
      .underrun_count (underrun_count),
`endif
      .fifo_level     (fifo_level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst     = 1'b1;
      enable  = 1'b0;
      s_valid = 1'b0;
      s_data  = 8'h00;
      #1;
      step(3);
      chk("rst_duty",  32'(pwm_duty), 32'h80);
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_tick",  32'(sample_tick), 32'd0);
      chk("rst_under", 32'(underrun), 32'd0);
      rst = 1'b0;
      step(1);
      chk("rst_ready", 32'(s_ready), 32'd1);

      // Prime with 8 samples; RUN is entered on the edge after level reaches 8.
      enable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(16 + i);
         step(1);
      end
      s_valid = 1'b0;
      chk("prime_level", 32'(fifo_level), 32'd8);
      chk("prime_duty",  32'(pwm_duty), 32'h80);
      step(1);

      // Playback: one sample every 256 clocks.
      for (int i = 0; i < 8; i++) begin
         step(255);
         chk("play_pre_tick", 32'(sample_tick), 32'd0);
         chk("play_pre_duty", 32'(pwm_duty), (i == 0) ? 32'h80 : 32'(16 + i - 1));
         step(1);
         chk("play_duty",  32'(pwm_duty), 32'(16 + i));
         chk("play_tick",  32'(sample_tick), 32'd1);
         chk("play_level", 32'(fifo_level), 32'(7 - i));
      end

      // Empty slots: duty holds, underrun pulses once per slot.
      for (int k = 0; k < 3; k++) begin
         step(255);
         chk("ur_pre", 32'(underrun), 32'd0);
         step(1);
         chk("ur_pulse", 32'(underrun), 32'd1);
         chk("ur_duty",  32'(pwm_duty), 32'h17);
         chk("ur_tick",  32'(sample_tick), 32'd0);
      end

      // Push into an empty FIFO in the slot cycle: underrun, sample stored.
      step(255);
`ifdef PWM_FEEDER_UNDERRUN_CNT_EN
      chk("ur_count3", 32'(underrun_count), 32'd3);
`endif
      s_valid = 1'b1;
      s_data  = 8'h55;
      step(1);
      s_valid = 1'b0;
      chk("slot_empty_under", 32'(underrun), 32'd1);
      chk("slot_empty_level", 32'(fifo_level), 32'd1);
      chk("slot_empty_duty",  32'(pwm_duty), 32'h17);

      // Push at slot with level 1: level unchanged, old head played.
      step(255);
      s_valid = 1'b1;
      s_data  = 8'h66;
      step(1);
      s_valid = 1'b0;
      chk("slot_pp_level", 32'(fifo_level), 32'd1);
      chk("slot_pp_duty",  32'(pwm_duty), 32'h55);
      chk("slot_pp_tick",  32'(sample_tick), 32'd1);
      step(256);
      chk("slot_next_duty",  32'(pwm_duty), 32'h66);
      chk("slot_next_level", 32'(fifo_level), 32'd0);

      // Drop enable mid-RUN at phase 100 with two samples queued.
      s_valid = 1'b1;
      s_data  = 8'h31;
      step(1);
      s_data  = 8'h32;
      step(1);
      s_valid = 1'b0;
      step(98);
      enable = 1'b0;
      step(1);
      chk("stop_duty",  32'(pwm_duty), 32'h80);
      chk("stop_level", 32'(fifo_level), 32'd2);
      chk("stop_tick",  32'(sample_tick), 32'd0);

      // Fill to DEPTH while stopped; an extra sample is held off.
      for (int i = 0; i < 14; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(8'h33 + i);
         step(1);
      end
      s_data = 8'h99;
      chk("full_level", 32'(fifo_level), 32'd16);
      chk("full_ready", 32'(s_ready), 32'd0);
      step(3);
      chk("full_hold_level", 32'(fifo_level), 32'd16);
      chk("full_hold_ready", 32'(s_ready), 32'd0);

      // Re-enable: PRIME then RUN straight away; retained head plays first.
      enable = 1'b1;
      step(2);
      step(255);
      chk("restart_pre_duty", 32'(pwm_duty), 32'h80);
      chk("restart_pre_lvl",  32'(fifo_level), 32'd16);
      step(1);
      chk("restart_duty",  32'(pwm_duty), 32'h31);
      chk("restart_tick",  32'(sample_tick), 32'd1);
      chk("restart_level", 32'(fifo_level), 32'd15);
      chk("restart_ready", 32'(s_ready), 32'd1);
      step(1);
      s_valid = 1'b0;
      chk("held_push_level", 32'(fifo_level), 32'd16);
      chk("held_push_ready", 32'(s_ready), 32'd0);

      // Asynchronous reset while RUN at phase 100.
      step(99);
`ifdef PWM_FEEDER_UNDERRUN_CNT_EN
      chk("ur_count4", 32'(underrun_count), 32'd4);
`endif
      rst = 1'b1;
      #1;
      chk("arst_duty",  32'(pwm_duty), 32'h80);
      chk("arst_level", 32'(fifo_level), 32'd0);
      chk("arst_tick",  32'(sample_tick), 32'd0);
      chk("arst_under", 32'(underrun), 32'd0);
`ifdef PWM_FEEDER_UNDERRUN_CNT_EN
      chk("arst_count", 32'(underrun_count), 32'd0);
`endif
      step(2);
      rst = 1'b0;
      step(1);
      chk("arst_ready", 32'(s_ready), 32'd1);

      // After reset, a fresh prime plays its first sample 256 clocks into RUN.
      for (int i = 0; i < 8; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(8'hA0 + i);
         step(1);
      end
      s_valid = 1'b0;
      step(1);
      step(255);
      chk("post_rst_pre_duty", 32'(pwm_duty), 32'h80);
      step(1);
      chk("post_rst_duty", 32'(pwm_duty), 32'hA0);
      chk("post_rst_tick", 32'(sample_tick), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pwm_sample_feeder.md
Name: pwm_sample_feeder

Overview:
Upstream stage of the 8-bit PWM generator. Buffers incoming 8-bit unsigned audio samples in a small FIFO (valid/ready input). Presents one sample as the PWM duty value per sample period. The sample period is a whole number of 256-cycle PWM periods, and duty changes only at a period boundary, so every PWM period sees a single stable duty value.

Parameters:
DEPTH, 16, FIFO depth in samples; power of two, minimum 4.
PERIODS_PER_SAMPLE, 4, PWM periods (256 clk each) per sample; sample rate = f_clk/(256*PERIODS_PER_SAMPLE); minimum 1.
IDLE_LEVEL, 8'h80, duty driven when not playing (midscale = silence).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
enable  in  1  level; 1 = play, 0 = stop
s_data  in  8  unsigned sample
s_valid  in  1  s_data valid
s_ready  out  1  FIFO can accept; equals (level < DEPTH)
pwm_duty  out  8  duty value to PWM stage (registered)
sample_tick  out  1  one-cycle pulse in the first cycle a new duty value is visible
underrun  out  1  one-cycle pulse when a sample slot finds the FIFO empty
fifo_level  out  $clog2(DEPTH)+1  samples held, 0..DEPTH

Behaviour:
- Reset (async, any time, including mid-playback):
  - FIFO emptied; phase and period counters cleared to 0.
  - State = IDLE; pwm_duty = IDLE_LEVEL.
  - sample_tick = 0, underrun = 0; s_ready = 1 from the first clock after rst deasserts.
- FIFO push rule:
  - A sample is pushed when s_valid && s_ready. Push works in every state.
  - s_data must be held while s_valid && !s_ready.
  - No push can occur when full (s_ready = 0).
- Counters:
  - 8-bit phase counter, wraps 255 -> 0.
  - period counter 0..PERIODS_PER_SAMPLE-1; advances when phase == 255.
  - Both counters run only in RUN and are held at 0 otherwise.
- Slot event: RUN && phase == 255 && period == PERIODS_PER_SAMPLE-1.
- State machine:
  - IDLE: duty = IDLE_LEVEL. Go to PRIME when enable = 1.
  - PRIME: duty = IDLE_LEVEL, counters held at 0. Go to RUN when fifo_level >= DEPTH/2; return to IDLE when enable = 0.
  - RUN: on each slot event, either
    - FIFO non-empty: pop the head; pwm_duty takes the popped value on the next clock edge (phase 0 of the next period); sample_tick pulses in that cycle.
    - FIFO empty: pwm_duty holds its last value; underrun pulses in the cycle after the slot event. State stays RUN (no re-prime).
  - RUN -> IDLE when enable = 0. On the next edge: duty = IDLE_LEVEL, counters = 0. FIFO contents are retained.
- Simultaneous push and pop: fifo_level unchanged, both operations complete.
- Push into an empty FIFO in the same cycle as a slot event: counts as an underrun; the new sample is stored and played at the next slot.
- Occupancy: fifo_level is a registered count. Pointers wrap modulo DEPTH.
- Start-up latency: first sample appears 256*PERIODS_PER_SAMPLE cycles after RUN is entered.

Optional Feature:
PWM_FEEDER_UNDERRUN_CNT_EN
- Defined: adds output port underrun_count[15:0]. It increments on each underrun pulse, saturates at 16'hFFFF, and clears only on rst.
- Not defined: the port and counter are absent; the underrun pulse is unchanged.

Decomposition:
- Shared package pwm_pkg holds:
  - PWM_WIDTH = 8 and PWM_PERIOD = 256 constants;
  - IDLE_LEVEL default;
  - feeder state typedef {IDLE, PRIME, RUN}.
- One sub-module, sample_fifo: synchronous single-clock FIFO, parameter DEPTH. It provides push/pop/level/full/empty, with first-word data on the read port (show-ahead).
- Phase/period counters and the FSM live in pwm_sample_feeder.

Test Plan:
1. Reset while RUN at phase 100 -> next cycle: pwm_duty = 8'h80, fifo_level = 0, state IDLE, no sample_tick.
2. DEPTH = 16, PERIODS_PER_SAMPLE = 1; push 8 samples 8'h10..8'h17 with enable = 1 -> state RUN once level = 8. Then:
   - duty = 8'h10 at cycle RUN+256, sample_tick pulses;
   - duty = 8'h11 at cycle RUN+512;
   - and so on through 8'h17.
3. Continue test 2 with no further pushes -> at the 9th slot: duty holds 8'h17 and underrun pulses once per slot. With PWM_FEEDER_UNDERRUN_CNT_EN, underrun_count = 3 after 3 empty slots.
4. Push 16 samples with enable = 0 -> s_ready = 0 and fifo_level = 16. A further s_valid is not accepted, and s_data is held until s_ready rises.
5. Push a sample in the exact cycle of a slot event with fifo_level = 1 -> level stays 1 and duty takes the old head. With fifo_level = 0, underrun pulses and level becomes 1.
6. Drop enable mid-RUN -> next cycle: duty = 8'h80, counters 0, FIFO level unchanged. Re-raise enable -> PRIME, then RUN immediately if level >= 8.
